// File: rtl/mac_r_frame_reader.sv
// RX MAC port reader: pops frame descriptors, streams good frames
// to the switch core with SOF/EOF, and flushes bad frames.
module mac_r_frame_reader #(
  parameter int MTU     = 1535,
  parameter int MIN_LEN = 60,
  parameter int FCS_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_sys,
  input  logic             rstn_sys,
  input  logic             ptr_fifo_empty,
  output logic             ptr_fifo_rd,
  input  logic [15:0]      ptr_fifo_dout,
  output logic             data_fifo_rd,
  input  logic [7:0]       data_fifo_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [11:0]      out_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FWD, S_FCS, S_DROP, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } beat_t;

  localparam logic [12:0] FCS_W = 13'(FCS_LEN);
  localparam logic [11:0] MIN_W = 12'(MIN_LEN);
  localparam logic [11:0] MTU_W = 12'(MTU);

  state_t      state_q, state_d;
  logic [12:0] rem_q;
  logic [11:0] len_q;
  logic [11:0] k_q;
  logic        rd_fwd_q;
  logic        eof_seen_q;
  beat_t       sb0_q, sb1_q;
  logic [1:0]  occ_q;

  logic [11:0] d_len;
  logic        d_drop;
  logic        pop;
  logic        push;
  logic        eof_pop;
  logic [2:0]  fill;
  beat_t       in_beat;
  logic        unused_rsvd;

  assign unused_rsvd = ptr_fifo_dout[12];
  assign d_len  = ptr_fifo_dout[11:0];
  assign d_drop = (|ptr_fifo_dout[15:13])
                | (d_len < MIN_W)
                | (d_len > MTU_W);

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = sb0_q.data;
  assign out_sof   = sb0_q.sof;
  assign out_eof   = sb0_q.eof;
  assign out_len   = len_q;

  assign pop     = out_valid & out_ready;
  assign push    = rd_fwd_q;
  assign eof_pop = pop & sb0_q.eof;
  // buffer level after this edge, counting the byte now arriving
  assign fill    = {1'b0, occ_q} + {2'b0, rd_fwd_q}
                 - {2'b0, pop};
  assign in_beat = {data_fifo_dout,
                    (k_q == 12'd0),
                    (k_q == (len_q - 12'd1))};

  // state register
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // next state and FIFO pops
  always_comb begin
    state_d      = state_q;
    ptr_fifo_rd  = 1'b0;
    data_fifo_rd = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!ptr_fifo_empty) begin
          ptr_fifo_rd = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: state_d = d_drop ? S_DROP : S_FWD;
      S_FWD: begin
        data_fifo_rd = (rem_q > FCS_W) && (fill < 3'd2);
        if (rem_q == FCS_W && !rd_fwd_q) state_d = S_FCS;
      end
      S_FCS: begin
        data_fifo_rd = 1'b1;
        if (rem_q == 13'd1) state_d = S_DONE;
      end
      S_DROP: begin
        data_fifo_rd = 1'b1;
        if (rem_q == 13'd1) state_d = S_IDLE;
      end
      S_DONE: begin
        if (eof_seen_q || eof_pop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // frame bookkeeping: remaining bytes, length, byte index
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      rem_q      <= '0;
      len_q      <= '0;
      k_q        <= '0;
      rd_fwd_q   <= 1'b0;
      eof_seen_q <= 1'b0;
    end else begin
      rd_fwd_q <= data_fifo_rd && (state_q == S_FWD);
      if (state_q == S_LOAD) begin
        rem_q      <= {1'b0, d_len} + FCS_W;
        k_q        <= '0;
        eof_seen_q <= 1'b0;
        if (!d_drop) len_q <= d_len;
      end else begin
        if (data_fifo_rd) rem_q <= rem_q - 13'd1;
        if (push)         k_q <= k_q + 12'd1;
        if (eof_pop)      eof_seen_q <= 1'b1;
      end
    end
  end

  // two-entry skid buffer, sb0 is the head
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      sb0_q <= '0;
      sb1_q <= '0;
      occ_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) sb0_q <= in_beat;
          else               sb1_q <= in_beat;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          sb0_q <= sb1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            sb0_q <= in_beat;
          end else begin
            sb0_q <= sb1_q;
            sb1_q <= in_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // saturating frame counters
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      good_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (eof_pop && good_cnt != '1)
        good_cnt <= good_cnt + CNT_W'(1);
      if (state_q == S_DROP && rem_q == 13'd1
          && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule
